// File: rtl/rbt_s_post_deparser.sv
// rtl/rbt_s_post_deparser.sv - post-deparser header stage: tuser rebuild, drop filter, 2-entry skid buffer
// Registered input ready; output fields come straight from the main register.
module rbt_s_post_deparser #(
  parameter int         HEADER_WIDTH       = 2048,
  parameter int         USER_WIDTH         = 36,
  parameter int         PKT_METADATA_WIDTH = 272,
  parameter logic [7:0] DROP_PORT          = 8'hFF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_proto_hdr_valid,
  output logic                          in_proto_hdr_ready,
  input  logic [HEADER_WIDTH-1:0]       in_proto_hdr_data,
  input  logic [PKT_METADATA_WIDTH-1:0] in_proto_hdr_pkt_metadata,
  input  logic [15:0]                   in_proto_hdr_length,
  output logic                          out_proto_hdr_valid,
  input  logic                          out_proto_hdr_ready,
  output logic [HEADER_WIDTH-1:0]       out_proto_hdr_data,
  output logic [15:0]                   out_proto_hdr_length,
  output logic [15:0]                   out_proto_hdr_pktlen,
  output logic [USER_WIDTH-1:0]         out_proto_hdr_tuser,
  output logic [31:0]                   drop_count,
  output logic [31:0]                   pkt_count
);

  if (HEADER_WIDTH % 8 != 0) begin : g_bad_header_width
    $error("HEADER_WIDTH must be a multiple of 8");
  end
  if (USER_WIDTH < 35) begin : g_bad_user_width
    $error("USER_WIDTH must be at least 35");
  end
  if (PKT_METADATA_WIDTH < 252) begin : g_bad_md_width
    $error("PKT_METADATA_WIDTH must be at least 252");
  end

  // Entry layout, MSB to LSB: {data, length, pktlen, tuser}
  localparam int EW = HEADER_WIDTH + 32 + USER_WIDTH;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e                state_q, state_d;
  logic [EW-1:0]         main_q, main_d, skid_q, skid_d;
  logic                  ready_q, ready_d;
  logic [31:0]           drop_q, drop_d, pkt_q, pkt_d;
  logic [USER_WIDTH-1:0] tuser_w;
  logic [EW-1:0]         in_entry;
  logic                  in_fire, out_fire, is_drop, push;
  logic                  unused_md;

  assign unused_md = ^in_proto_hdr_pkt_metadata;

  always_comb begin
    tuser_w        = '0;
    tuser_w[34:0]  = {in_proto_hdr_pkt_metadata[245:241],
                      in_proto_hdr_pkt_metadata[251:246],
                      in_proto_hdr_pkt_metadata[23:0]};
  end

  assign in_entry = {in_proto_hdr_data, in_proto_hdr_length,
                     in_proto_hdr_pkt_metadata[39:24], tuser_w};

  assign out_proto_hdr_valid  = (state_q != EMPTY);
  assign in_proto_hdr_ready   = ready_q;
  assign out_proto_hdr_tuser  = main_q[USER_WIDTH-1:0];
  assign out_proto_hdr_pktlen = main_q[USER_WIDTH+15:USER_WIDTH];
  assign out_proto_hdr_length = main_q[USER_WIDTH+31:USER_WIDTH+16];
  assign out_proto_hdr_data   = main_q[EW-1:USER_WIDTH+32];
  assign drop_count           = drop_q;
  assign pkt_count            = pkt_q;

  assign in_fire  = in_proto_hdr_valid & ready_q;
  assign out_fire = out_proto_hdr_valid & out_proto_hdr_ready;
  assign is_drop  = (in_proto_hdr_pkt_metadata[15:8] == DROP_PORT);
  assign push     = in_fire & ~is_drop;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          main_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && out_fire) begin
          main_d = in_entry;
        end else if (push) begin
          skid_d  = in_entry;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Skid refills main; ready is low here, so push only guards against misuse
        if (out_fire) begin
          main_d = skid_q;
          if (push) skid_d = in_entry;
          else      state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    ready_d = (state_d != FULL);
    drop_d  = (in_fire && is_drop && drop_q != 32'hFFFF_FFFF) ? drop_q + 32'd1 : drop_q;
    pkt_d   = (out_fire && pkt_q != 32'hFFFF_FFFF) ? pkt_q + 32'd1 : pkt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      drop_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      drop_q  <= drop_d;
      pkt_q   <= pkt_d;
    end
  end

endmodule
